// File: rtl/cpu7_lsu.sv
// cpu7_lsu: single-outstanding load/store unit between cpu7_exu and the dcache handshake bus
module cpu7_lsu #(
  parameter int GRLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [3:0]       lsu_op,
  input  logic [GRLEN-1:0] lsu_base,
  input  logic [GRLEN-1:0] lsu_offset,
  input  logic [GRLEN-1:0] lsu_wdata,
  input  logic [4:0]       lsu_rd,
  input  logic [GRLEN-1:0] lsu_pc,
  input  logic             lsu_cancel,
  output logic             data_req,
  output logic             data_wr,
  output logic [GRLEN-1:0] data_addr,
  output logic [GRLEN-1:0] data_pc,
  output logic [GRLEN-1:0] data_wdata,
  output logic [3:0]       data_wstrb,
  output logic             data_recv,
  output logic             data_cancel,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  input  logic [GRLEN-1:0] data_rdata,
  input  logic             data_exception,
  input  logic [5:0]       data_exccode,
  input  logic [GRLEN-1:0] data_badvaddr,
  output logic             lsu_wb_valid,
  output logic             lsu_wb_wen,
  output logic [4:0]       lsu_wb_rd,
  output logic [GRLEN-1:0] lsu_wb_data,
  output logic             lsu_wb_ex,
  output logic [5:0]       lsu_wb_exccode,
  output logic [GRLEN-1:0] lsu_wb_badvaddr
);
  typedef enum logic [2:0] {IDLE, ALE, REQ, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic st_q, st_d, uns_q, uns_d;
  logic [1:0] size_q, size_d;
  logic [4:0] rd_q, rd_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [GRLEN-1:0] addr_q, addr_d, pc_q, pc_d, wdata_q, wdata_d;
  logic wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, wb_ex_q, wb_ex_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic [5:0] wb_exc_q, wb_exc_d;
  logic [GRLEN-1:0] wb_data_q, wb_data_d, wb_bad_q, wb_bad_d;
  logic [GRLEN-1:0] ea, wrep, ld;
  logic [7:0] rb;
  logic [15:0] rh;
  logic [3:0] strb;
  logic mis, fin;
  // size 1x is a word; 01 half; 00 byte
  assign ea = lsu_base + lsu_offset;
  assign mis = lsu_op[1] ? |ea[1:0] : lsu_op[0] & ea[0];
  assign strb = lsu_op[1] ? 4'hf : (lsu_op[0] ? 4'b0011 : 4'b0001) << ea[1:0];
  assign wrep = lsu_op[1] ? lsu_wdata : lsu_op[0] ? {(GRLEN/16){lsu_wdata[15:0]}} : {(GRLEN/8){lsu_wdata[7:0]}};
  assign rb = data_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign rh = data_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ld = size_q[1] ? data_rdata : size_q[0] ? {{(GRLEN-16){~uns_q & rh[15]}}, rh} : {{(GRLEN-8){~uns_q & rb[7]}}, rb};
  assign lsu_ready = state_q == IDLE;
  assign data_req = state_q == REQ;
  assign data_wr = data_req & st_q;
  assign data_addr = addr_q;
  assign data_pc = pc_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;
  assign data_recv = state_q == REQ || state_q == WAIT || state_q == DRAIN;
  assign data_cancel = lsu_cancel & ((data_req & data_addr_ok & ~data_data_ok) | (state_q == WAIT & ~data_data_ok));
  assign lsu_wb_valid = wb_valid_q;
  assign lsu_wb_wen = wb_wen_q;
  assign lsu_wb_rd = wb_rd_q;
  assign lsu_wb_data = wb_data_q;
  assign lsu_wb_ex = wb_ex_q;
  assign lsu_wb_exccode = wb_exc_q;
  assign lsu_wb_badvaddr = wb_bad_q;
  // next state, op latch and registered completion
  always_comb begin
    state_d = state_q;
    st_d = st_q;
    uns_d = uns_q;
    size_d = size_q;
    rd_d = rd_q;
    wstrb_d = wstrb_q;
    addr_d = addr_q;
    pc_d = pc_q;
    wdata_d = wdata_q;
    wb_valid_d = 1'b0;
    wb_wen_d = 1'b0;
    wb_ex_d = 1'b0;
    wb_rd_d = '0;
    wb_exc_d = '0;
    wb_data_d = '0;
    wb_bad_d = '0;
    fin = 1'b0;
    case (state_q)
      IDLE: if (lsu_valid && !lsu_cancel) begin
        st_d = lsu_op[3];
        uns_d = lsu_op[2];
        size_d = lsu_op[1:0];
        rd_d = lsu_rd;
        addr_d = ea;
        pc_d = lsu_pc;
        wstrb_d = lsu_op[3] ? strb : 4'h0;
        wdata_d = lsu_op[3] ? wrep : '0;
        state_d = mis ? ALE : REQ;
      end
      ALE: begin
        state_d = IDLE;
        wb_valid_d = ~lsu_cancel;
        wb_ex_d = ~lsu_cancel;
        wb_rd_d = lsu_cancel ? 5'd0 : rd_q;
        wb_exc_d = lsu_cancel ? 6'h00 : 6'h09;
        wb_bad_d = lsu_cancel ? '0 : addr_q;
      end
      REQ: if (lsu_cancel) state_d = (data_addr_ok && !data_data_ok) ? DRAIN : IDLE;
        else if (data_addr_ok) begin
          fin = data_data_ok;
          state_d = data_data_ok ? IDLE : WAIT;
        end
      WAIT: begin
        fin = data_data_ok;
        state_d = data_data_ok ? IDLE : lsu_cancel ? DRAIN : WAIT;
      end
      DRAIN: state_d = data_data_ok ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    if (fin) begin
      wb_valid_d = 1'b1;
      wb_ex_d = data_exception;
      wb_wen_d = ~st_q & ~data_exception;
      wb_rd_d = rd_q;
      wb_data_d = (~st_q & ~data_exception) ? ld : '0;
      wb_exc_d = data_exception ? data_exccode : 6'h00;
      wb_bad_d = data_exception ? data_badvaddr : '0;
    end
  end
  // state and output registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      st_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= 2'b00;
      rd_q <= '0;
      wstrb_q <= '0;
      addr_q <= '0;
      pc_q <= '0;
      wdata_q <= '0;
      wb_valid_q <= 1'b0;
      wb_wen_q <= 1'b0;
      wb_ex_q <= 1'b0;
      wb_rd_q <= '0;
      wb_exc_q <= '0;
      wb_data_q <= '0;
      wb_bad_q <= '0;
    end else begin
      state_q <= state_d;
      st_q <= st_d;
      uns_q <= uns_d;
      size_q <= size_d;
      rd_q <= rd_d;
      wstrb_q <= wstrb_d;
      addr_q <= addr_d;
      pc_q <= pc_d;
      wdata_q <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_wen_q <= wb_wen_d;
      wb_ex_q <= wb_ex_d;
      wb_rd_q <= wb_rd_d;
      wb_exc_q <= wb_exc_d;
      wb_data_q <= wb_data_d;
      wb_bad_q <= wb_bad_d;
    end
  end
endmodule

// File: tb/tb_cpu7_lsu.sv
// tb_cpu7_lsu: directed scenario bench for cpu7_lsu
module tb_cpu7_lsu;
  logic clk, reset, lsu_valid, lsu_ready, lsu_cancel;
  logic [3:0] lsu_op;
  logic [31:0] lsu_base, lsu_offset, lsu_wdata, lsu_pc;
  logic [4:0] lsu_rd;
  logic data_req, data_wr, data_recv, data_cancel;
  logic [31:0] data_addr, data_pc, data_wdata;
  logic [3:0] data_wstrb;
  logic data_addr_ok, data_data_ok, data_exception;
  logic [31:0] data_rdata, data_badvaddr;
  logic [5:0] data_exccode;
  logic lsu_wb_valid, lsu_wb_wen, lsu_wb_ex;
  logic [4:0] lsu_wb_rd;
  logic [31:0] lsu_wb_data, lsu_wb_badvaddr;
  logic [5:0] lsu_wb_exccode;
  int n_tests = 0, n_fail = 0;

  cpu7_lsu #(.GRLEN(32)) dut (
    .clk(clk), .reset(reset), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_op(lsu_op),
    .lsu_base(lsu_base), .lsu_offset(lsu_offset), .lsu_wdata(lsu_wdata), .lsu_rd(lsu_rd),
    .lsu_pc(lsu_pc), .lsu_cancel(lsu_cancel), .data_req(data_req), .data_wr(data_wr),
    .data_addr(data_addr), .data_pc(data_pc), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_recv(data_recv), .data_cancel(data_cancel), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .data_exception(data_exception),
    .data_exccode(data_exccode), .data_badvaddr(data_badvaddr), .lsu_wb_valid(lsu_wb_valid),
    .lsu_wb_wen(lsu_wb_wen), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ex(lsu_wb_ex), .lsu_wb_exccode(lsu_wb_exccode), .lsu_wb_badvaddr(lsu_wb_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_in();
    lsu_valid = 0; lsu_cancel = 0; lsu_op = 0; lsu_base = 0; lsu_offset = 0; lsu_wdata = 0;
    lsu_rd = 0; lsu_pc = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    data_exception = 0; data_exccode = 0; data_badvaddr = 0;
  endtask

  // next cycle with quiet inputs; returns 1ns after the falling edge
  task automatic tick();
    @(negedge clk);
    clear_in();
    #1;
  endtask

  // present op in cycle 0, return in cycle 1 with lsu_valid dropped
  task automatic issue(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc);
    @(negedge clk);
    clear_in();
    lsu_valid = 1; lsu_op = op; lsu_base = base; lsu_offset = off; lsu_wdata = wd; lsu_rd = rd; lsu_pc = pc;
    #1;
    @(negedge clk);
    clear_in();
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", lsu_ready); end
    n_tests++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", data_req); end
    n_tests++; if ({data_addr, data_wdata, data_pc} !== 96'h0) begin n_fail++; $display("FAIL reset_bus got %h %h %h exp 0", data_addr, data_wdata, data_pc); end
    n_tests++; if ({data_wstrb, data_wr, data_recv, data_cancel} !== 7'h0) begin n_fail++; $display("FAIL reset_ctl got %b%b%b%b exp 0", data_wstrb, data_wr, data_recv, data_cancel); end
    n_tests++; if ({lsu_wb_valid, lsu_wb_wen, lsu_wb_ex, lsu_wb_data, lsu_wb_badvaddr} !== 67'h0) begin n_fail++; $display("FAIL reset_wb got %b %h %h exp 0", lsu_wb_valid, lsu_wb_data, lsu_wb_badvaddr); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_lw();
    issue(4'b0010, 32'h1000, 32'h4, 32'h0, 5'd5, 32'h80);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'hDEADBEEF;
    n_tests++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL lw_req got %b exp 1", data_req); end
    n_tests++; if (data_addr !== 32'h1004) begin n_fail++; $display("FAIL lw_addr got %h exp 00001004", data_addr); end
    n_tests++; if ({data_wstrb, data_wr} !== 5'b0) begin n_fail++; $display("FAIL lw_wstrb got %b wr %b exp 0", data_wstrb, data_wr); end
    n_tests++; if (data_pc !== 32'h80) begin n_fail++; $display("FAIL lw_pc got %h exp 00000080", data_pc); end
    n_tests++; if (lsu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL lw_early_wb got %b exp 0", lsu_wb_valid); end
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_wb_wen, lsu_wb_ex} !== 3'b110) begin n_fail++; $display("FAIL lw_wb_flags got %b exp 110", {lsu_wb_valid, lsu_wb_wen, lsu_wb_ex}); end
    n_tests++; if (lsu_wb_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", lsu_wb_data); end
    n_tests++; if (lsu_wb_rd !== 5'd5) begin n_fail++; $display("FAIL lw_rd got %0d exp 5", lsu_wb_rd); end
    n_tests++; if ({lsu_ready, data_req} !== 2'b10) begin n_fail++; $display("FAIL lw_ready got %b req %b exp 1 0", lsu_ready, data_req); end
    tick();
    n_tests++; if (lsu_wb_valid !== 1'b0) begin n_fail++; $display("FAIL lw_pulse got %b exp 0", lsu_wb_valid); end
  endtask

  task automatic test_sub_word_loads();
    logic [3:0] ops [4] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101};
    logic [31:0] offs [4] = '{32'h3, 32'h3, 32'h2, 32'h2};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 32'h2000, offs[i], 32'h0, 5'd7, 32'h100);
      data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h80FFFFFF;
      tick();
      n_tests++; if ({lsu_wb_valid, lsu_wb_wen, lsu_wb_data} !== {2'b11, exp[i]}) begin n_fail++; $display("FAIL load_ext%0d got %b%b %h exp 11 %h", i, lsu_wb_valid, lsu_wb_wen, lsu_wb_data, exp[i]); end
    end
  endtask

  task automatic test_store();
    issue(4'b1001, 32'h3000, 32'h2, 32'h1234ABCD, 5'd0, 32'h200);
    data_addr_ok = 1; data_data_ok = 1;
    n_tests++; if ({data_req, data_wr, data_wstrb} !== 6'b111100) begin n_fail++; $display("FAIL sh_ctl got %b%b %b exp 11 1100", data_req, data_wr, data_wstrb); end
    n_tests++; if (data_wdata !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", data_wdata); end
    n_tests++; if (data_addr !== 32'h3002) begin n_fail++; $display("FAIL sh_addr got %h exp 00003002", data_addr); end
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_wb_wen, lsu_wb_ex} !== 3'b100) begin n_fail++; $display("FAIL sh_wb got %b exp 100", {lsu_wb_valid, lsu_wb_wen, lsu_wb_ex}); end
    issue(4'b1000, 32'h3000, 32'h1, 32'hA5A5A555, 5'd0, 32'h204);
    data_addr_ok = 1; data_data_ok = 1;
    n_tests++; if ({data_wstrb, data_wdata} !== {4'b0010, 32'h55555555}) begin n_fail++; $display("FAIL sb_fields got %b %h exp 0010 55555555", data_wstrb, data_wdata); end
    tick();
    issue(4'b1010, 32'h3000, 32'h4, 32'h0BADF00D, 5'd0, 32'h208);
    data_addr_ok = 1; data_data_ok = 1;
    n_tests++; if ({data_wstrb, data_wdata} !== {4'b1111, 32'h0BADF00D}) begin n_fail++; $display("FAIL sw_fields got %b %h exp 1111 0badf00d", data_wstrb, data_wdata); end
    tick();
  endtask

  task automatic test_ale();
    issue(4'b0010, 32'h1000, 32'h2, 32'h0, 5'd9, 32'h300);
    n_tests++; if ({data_req, lsu_ready} !== 2'b00) begin n_fail++; $display("FAIL ale_noreq got req %b ready %b exp 0 0", data_req, lsu_ready); end
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_wb_ex, lsu_wb_wen} !== 3'b110) begin n_fail++; $display("FAIL ale_flags got %b exp 110", {lsu_wb_valid, lsu_wb_ex, lsu_wb_wen}); end
    n_tests++; if ({lsu_wb_exccode, lsu_wb_badvaddr} !== {6'h09, 32'h1002}) begin n_fail++; $display("FAIL ale_code got %h %h exp 09 00001002", lsu_wb_exccode, lsu_wb_badvaddr); end
    n_tests++; if ({lsu_ready, data_req} !== 2'b10) begin n_fail++; $display("FAIL ale_ready got %b req %b exp 1 0", lsu_ready, data_req); end
    issue(4'b1001, 32'h3001, 32'h0, 32'h0, 5'd0, 32'h304);
    n_tests++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL ale_sh_req got %b exp 0", data_req); end
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_wb_ex, lsu_wb_badvaddr} !== {2'b11, 32'h3001}) begin n_fail++; $display("FAIL ale_sh got %b%b %h exp 11 00003001", lsu_wb_valid, lsu_wb_ex, lsu_wb_badvaddr); end
    issue(4'b0010, 32'h1000, 32'h3, 32'h0, 5'd9, 32'h308);
    lsu_cancel = 1;
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_ready} !== 2'b01) begin n_fail++; $display("FAIL ale_cancel got wb %b ready %b exp 0 1", lsu_wb_valid, lsu_ready); end
  endtask

  task automatic test_wrap();
    issue(4'b0010, 32'h00000002, 32'hFFFFFFFE, 32'h0, 5'd3, 32'h400);
    n_tests++; if ({data_req, data_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_addr got %b %h exp 1 00000000", data_req, data_addr); end
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h01020304;
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_wb_ex, lsu_wb_data} !== {2'b10, 32'h01020304}) begin n_fail++; $display("FAIL wrap_wb got %b%b %h exp 10 01020304", lsu_wb_valid, lsu_wb_ex, lsu_wb_data); end
  endtask

  task automatic test_cancel();
    logic seen = 0;
    issue(4'b0010, 32'h4000, 32'h0, 32'h0, 5'd4, 32'h500);
    data_addr_ok = 1;
    tick();
    lsu_cancel = 1;
    #1;
    n_tests++; if ({data_cancel, data_recv, data_req} !== 3'b110) begin n_fail++; $display("FAIL cancel_pulse got %b exp 110", {data_cancel, data_recv, data_req}); end
    for (int c = 3; c <= 5; c++) begin
      tick();
      if (c == 5) begin data_data_ok = 1; data_rdata = 32'hFFFFFFFF; end
      #1;
      seen = seen | lsu_wb_valid;
      n_tests++; if ({data_cancel, lsu_ready, data_recv} !== 3'b001) begin n_fail++; $display("FAIL cancel_drain%0d got %b exp 001", c, {data_cancel, lsu_ready, data_recv}); end
    end
    tick();
    seen = seen | lsu_wb_valid;
    n_tests++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL cancel_ready got %b exp 1", lsu_ready); end
    tick();
    seen = seen | lsu_wb_valid;
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_nowb got %b exp 0", seen); end
    issue(4'b0010, 32'h4000, 32'h8, 32'h0, 5'd4, 32'h504);
    lsu_cancel = 1;
    tick();
    n_tests++; if ({lsu_ready, data_req, lsu_wb_valid} !== 3'b100) begin n_fail++; $display("FAIL cancel_req got %b exp 100", {lsu_ready, data_req, lsu_wb_valid}); end
  endtask

  task automatic test_stall_exception();
    issue(4'b0010, 32'h5000, 32'h8, 32'h0, 5'd6, 32'h600);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      if (c == 4) data_addr_ok = 1;
      n_tests++; if ({data_req, data_addr} !== {1'b1, 32'h5008}) begin n_fail++; $display("FAIL stall_req%0d got %b %h exp 1 00005008", c, data_req, data_addr); end
    end
    tick();
    data_data_ok = 1; data_exception = 1; data_exccode = 6'h01; data_badvaddr = 32'h5008; data_rdata = 32'h12345678;
    n_tests++; if ({data_req, data_recv} !== 2'b01) begin n_fail++; $display("FAIL stall_wait got req %b recv %b exp 0 1", data_req, data_recv); end
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_wb_ex, lsu_wb_wen} !== 3'b110) begin n_fail++; $display("FAIL stall_ex got %b exp 110", {lsu_wb_valid, lsu_wb_ex, lsu_wb_wen}); end
    n_tests++; if ({lsu_wb_exccode, lsu_wb_badvaddr} !== {6'h01, 32'h5008}) begin n_fail++; $display("FAIL stall_code got %h %h exp 01 00005008", lsu_wb_exccode, lsu_wb_badvaddr); end
  endtask

  task automatic test_back_to_back();
    issue(4'b0010, 32'h6000, 32'h0, 32'h0, 5'd1, 32'h700);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h11111111;
    @(negedge clk);
    clear_in();
    lsu_valid = 1; lsu_op = 4'b0001; lsu_base = 32'h6010; lsu_offset = 32'h2; lsu_rd = 5'd2; lsu_pc = 32'h704;
    #1;
    n_tests++; if ({lsu_wb_valid, lsu_ready, lsu_wb_data} !== {2'b11, 32'h11111111}) begin n_fail++; $display("FAIL b2b_first got %b%b %h exp 11 11111111", lsu_wb_valid, lsu_ready, lsu_wb_data); end
    tick();
    data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h7FFF0000;
    n_tests++; if ({data_req, data_addr} !== {1'b1, 32'h6012}) begin n_fail++; $display("FAIL b2b_req got %b %h exp 1 00006012", data_req, data_addr); end
    tick();
    n_tests++; if ({lsu_wb_valid, lsu_wb_rd, lsu_wb_data} !== {1'b1, 5'd2, 32'h00007FFF}) begin n_fail++; $display("FAIL b2b_second got %b %0d %h exp 1 2 00007fff", lsu_wb_valid, lsu_wb_rd, lsu_wb_data); end
  endtask

  task automatic test_reset_mid_op();
    issue(4'b0010, 32'h7000, 32'h0, 32'h0, 5'd8, 32'h800);
    data_addr_ok = 1;
    tick();
    reset = 1;
    tick();
    reset = 0;
    n_tests++; if ({lsu_ready, data_req, data_recv, data_cancel, lsu_wb_valid} !== 5'b10000) begin n_fail++; $display("FAIL midreset got %b exp 10000", {lsu_ready, data_req, data_recv, data_cancel, lsu_wb_valid}); end
  endtask

  initial begin
    reset = 1;
    clear_in();
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_store();
    test_ale();
    test_wrap();
    test_cancel();
    test_stall_exception();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
